count_display_driver: RTL
=========================

Name: count_display_driver

Overview:
- Downstream consumer of the 5-bit up/down counter output `d` and its `mode` select.
- Registers the count and converts it to two BCD digits with a sequential double-dabble converter.
- Drives a time-multiplexed two-digit common-anode 7-segment display.
- Decimal point on the ones digit indicates `mode`=1.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays enabled. Must be >= 2.
- SEG_ACTIVE_LOW, 1: 1 means seg and dp are active-low; 0 means active-high.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- d  input  5  counter value, 0..31. Treated as an asynchronous data source and registered on entry.
- mode  input  1  counter mode. Registered, then shown on dp.
- seg  output  7  segments {g,f,e,d,c,b,a}, seg[0]=a; registered.
- dp  output  1  decimal point; registered.
- an  output  2  digit enables, active-low: an[0]=ones, an[1]=tens; registered.
- tens  output  4  BCD tens digit of last completed conversion.
- ones  output  4  BCD ones digit of last completed conversion.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (rst=0, immediate, no clock needed):
  - d_q=0, mode_q=0, last_conv=0, tens=0, ones=0, busy=0.
  - FSM=IDLE, refresh count=0, sel=0.
  - seg=all off (7'h7F when SEG_ACTIVE_LOW=1), dp=off, an=2'b11.
- Input capture: d_q<=d and mode_q<=mode on every edge.
- Converter FSM, IDLE -> SHIFT -> DONE -> IDLE:
  - IDLE: when d_q != last_conv, load bin<=d_q, bcd<=8'h00, cnt<=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: on each edge, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1 and increment cnt. After the fifth shift (cnt==4 on that edge) go to DONE.
  - DONE: tens<=bcd[7:4], ones<=bcd[3:0], last_conv<=converted value, go to IDLE.
  - busy=1 in SHIFT and DONE, i.e. exactly 6 cycles per conversion.
- Latency, counting the edge where d_q captures a new value as edge 0:
  - edge 1: load; edges 2-6: shifts; edge 7: tens/ones update.
  - tens/ones therefore update at the 8th edge after d changes.
- d changing during a conversion:
  - The in-flight conversion completes with the value it loaded.
  - IDLE then sees d_q != last_conv and restarts.
  - The displayed value always converges to the final d. Only values that were actually loaded are ever shown.
- Equal values: no conversion starts when d_q == last_conv, including d=0 after reset.
- Refresh timing:
  - The counter runs 0..REFRESH_DIV-1 and wraps.
  - On wrap, sel toggles. sel=0 selects the ones digit, sel=1 the tens digit.
- Digit outputs, registered one edge after sel/tens/ones:
  - sel=0: an=2'b10, seg=pattern(ones).
  - sel=1 and tens!=0: an=2'b01, seg=pattern(tens).
  - sel=1 and tens==0 (leading-zero blanking): an=2'b11, seg=blank.
- dp: active only when sel=0 and mode_q=1; otherwise off.
- Segment patterns, active-low form, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10-15: blank. Unreachable, but must be defined.
  - When SEG_ACTIVE_LOW=0, seg and dp are bitwise inverted.
- Async reset asserted mid-SHIFT aborts the conversion. After release, the normal IDLE compare restarts conversion if d != 0.

Decomposition:
- Package counter_display_pkg:
  - conversion state enum (IDLE, SHIFT, DONE);
  - SEG_BLANK constant;
  - digit-to-segment constant table/function, active-low form;
  - DIGIT_ONES/DIGIT_TENS select constants.
- Sub-module bin5_to_bcd:
  - sequential double-dabble converter with ports clk, rst, start, bin[4:0], busy, done, tens, ones;
  - the top level holds capture/compare, refresh and segment logic.

Test Plan (REFRESH_DIV=4, SEG_ACTIVE_LOW=1):
- Reset check: hold rst=0 -> seg=7'h7F, an=2'b11, busy=0, tens=ones=0. Release with d=0 -> busy never rises; an=2'b10 with seg=1000000, alternating with an=2'b11 (tens blanked) every 4 cycles.
- d=23 applied and held -> busy high exactly 6 cycles; tens=2, ones=3 at the 8th edge. Display shows an=01/seg=0100100 and an=10/seg=0110000.
- Boundary values: d=31 -> tens=3, ones=1. d=9 -> tens=0, ones=9, an never 2'b01. d=10 -> tens=1, ones=0.
- Change during conversion: d=10, then d=17 two cycles after busy rises -> tens/ones go 1/0, then after a second 6-cycle busy pulse 1/7; no other value ever appears.
- Mode indicator: mode=1 -> dp=0 only while an=2'b10, otherwise 1. mode=0 -> dp=1 always.
- Reset mid-conversion: rst=0 two cycles into SHIFT -> outputs reach reset values with no clock edge. Release with d=12 -> tens=1, ones=2 after one 6-cycle busy pulse.

Source files
------------

// File: rtl/counter_display_pkg.sv
// Shared types and constants for the count display driver: converter states,
// digit-select encoding and the active-low seven-segment table.
package counter_display_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_e;

  localparam logic [6:0] SegBlank  = 7'h7F;
  localparam logic       DigitOnes = 1'b0;
  localparam logic       DigitTens = 1'b1;

  // Active-low {g,f,e,d,c,b,a}; codes above 9 are blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SegBlank;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin5_to_bcd.sv
// Sequential double-dabble converter: 5-bit binary to two BCD digits,
// one load cycle, five shift cycles and one result-commit cycle.
module bin5_to_bcd
  import counter_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  conv_state_e state_q, state_d;
  logic [4:0]  bin_q, bin_d;
  logic [7:0]  bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [7:0]  bcd_adj;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;

    case (state_q)
      StIdle: begin
        if (start) begin
          bin_d   = bin;
          bcd_d   = 8'h00;
          cnt_d   = 3'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        {bcd_d, bin_d} = {bcd_adj[6:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 3'd1;
        if (cnt_q == 3'd4) state_d = StDone;
      end
      StDone: begin
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      bin_q   <= 5'd0;
      bcd_q   <= 8'h00;
      cnt_q   <= 3'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/count_display_driver.sv
// Captures the counter value and mode, converts the count to BCD and drives a
// two-digit multiplexed common-anode display with leading-zero blanking.
module count_display_driver
  import counter_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d,
  input  logic       mode,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy
);

  localparam int unsigned CntW   = $clog2(REFRESH_DIV);
  localparam logic [6:0]  SegOff = SEG_ACTIVE_LOW ? SegBlank : ~SegBlank;
  localparam logic        DpOff  = SEG_ACTIVE_LOW;

  logic [4:0]      d_q, d_d;
  logic            mode_q, mode_d;
  logic [4:0]      last_conv_q, last_conv_d;
  logic [4:0]      loaded_q, loaded_d;
  logic [CntW-1:0] refresh_q, refresh_d;
  logic            sel_q, sel_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [1:0]      an_q, an_d;

  logic       conv_start, conv_busy, conv_done;
  logic [6:0] seg_raw;
  logic       dp_on;

  // The converter ignores start unless idle, so the compare can run freely.
  assign conv_start = (d_q != last_conv_q) && !conv_busy;

  bin5_to_bcd u_bin5_to_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (d_q),
    .busy  (conv_busy),
    .done  (conv_done),
    .tens  (tens),
    .ones  (ones)
  );

  always_comb begin
    d_d         = d;
    mode_d      = mode;
    loaded_d    = conv_start ? d_q : loaded_q;
    last_conv_d = conv_done ? loaded_q : last_conv_q;

    if (refresh_q == CntW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      sel_d     = ~sel_q;
    end else begin
      refresh_d = refresh_q + 1'b1;
      sel_d     = sel_q;
    end

    an_d    = 2'b11;
    seg_raw = SegBlank;
    dp_on   = 1'b0;
    if (sel_q == DigitOnes) begin
      an_d    = 2'b10;
      seg_raw = seg_pattern(ones);
      dp_on   = mode_q;
    end else if (tens != 4'd0) begin
      an_d    = 2'b01;
      seg_raw = seg_pattern(tens);
    end
    seg_d = SEG_ACTIVE_LOW ? seg_raw : ~seg_raw;
    dp_d  = SEG_ACTIVE_LOW ? ~dp_on : dp_on;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q         <= 5'd0;
      mode_q      <= 1'b0;
      last_conv_q <= 5'd0;
      loaded_q    <= 5'd0;
      refresh_q   <= '0;
      sel_q       <= DigitOnes;
      seg_q       <= SegOff;
      dp_q        <= DpOff;
      an_q        <= 2'b11;
    end else begin
      d_q         <= d_d;
      mode_q      <= mode_d;
      last_conv_q <= last_conv_d;
      loaded_q    <= loaded_d;
      refresh_q   <= refresh_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg  = seg_q;
  assign dp   = dp_q;
  assign an   = an_q;
  assign busy = conv_busy;

endmodule
